multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle successor to the single-cycle main control decoder. Sequences each instruction through fetch, decode, execute, memory and write-back states, so the datapath can share one memory port and one ALU. Emits per-state datapath strobes plus the same 3-bit ALU-op encoding consumed by the existing ALU control block. Adds a memory ready handshake, opcode-width generalisation and an illegal-opcode trap.

## Interface
- OPW, 4: opcode width, minimum 4; any nonzero bit above bit 3 makes the opcode illegal.
- FUNCW, 3: func field width; `func` is passed through to `func_q`.
- CNT_W, 32: width of the performance counters; used only when the performance counters are compiled in.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  OPW  instruction opcode from IR, sampled in DECODE
- func  in  FUNCW  func field, sampled in DECODE
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request (FETCH, MEM)
- mem_we  out  1  write request (MEM of SW)
- iord  out  1  0 = instruction address, 1 = data address
- ir_write  out  1  load IR (FETCH and mem_ready)
- pc_inc  out  1  increment PC (FETCH and mem_ready)
- alu_op  out  3  ALU-op to ALU control
- func_q  out  FUNCW  latched func
- alu_src  out  1  ALU B operand = immediate
- branch  out  1  branch evaluate strobe
- branch_ne  out  1  branch sense is not-equal
- reg_dst  out  1  destination register = rd
- mem_to_reg  out  1  write-back data from memory
- reg_write  out  1  register file write strobe
- illegal  out  1  sticky illegal-opcode flag
- instr_count, cycle_count  out  CNT_W  performance counters; exist only when the performance counters are compiled in

## Operation
- Opcode classes, decoded from opcode[3:0] with upper bits zero:
  - R-type: 0000; alu_op 000.
  - I-type: 0001, 0010, 0011, 0100 and 0111; alu_op = 001, 010, 011, 100 and 110 respectively.
  - Branch: 0101 (BEQ) and 0110 (BNE); alu_op 101.
  - LW: 1000; alu_op 111.
  - SW: 1001; alu_op 111.
  - Illegal: 1010–1111, or any upper opcode bit set.
- State machine and transitions:
  - FETCH: if mem_ready, go to DECODE; otherwise hold.
  - DECODE: latch the class, alu_op and func_q. Illegal opcode goes to TRAP; every other class goes to EXEC.
  - EXEC: R-type and I-type go to WB. LW and SW go to MEM. Branch goes to FETCH.
  - MEM: if mem_ready, LW goes to WB and SW goes to FETCH; otherwise hold.
  - WB: go to FETCH.
  - TRAP: terminal; left only by rst.
- Outputs are Moore, except ir_write and pc_inc, which equal FETCH & mem_ready.
  - FETCH: mem_req=1, iord=0.
  - EXEC: alu_src=1 for I-type, LW and SW. Branch class also drives branch=1, and branch_ne=1 for opcode 0110.
  - MEM: mem_req=1, iord=1, mem_we=SW, alu_src=1.
  - WB: reg_write=1, reg_dst=R-type, mem_to_reg=LW.
  - TRAP: all strobes 0, illegal=1.
- alu_op and func_q hold their latched values from DECODE until the next DECODE. They are 0 from reset until the first DECODE.
- Asserting mem_ready outside FETCH and MEM is ignored.

## Timing
- Reset: the state goes to FETCH asynchronously. Every output is 0, including illegal, alu_op, func_q and the counters. mem_req rises in the first clk after rst falls.
- Reset mid-operation, including a held MEM: strobes drop immediately; no partial write-back is emitted.
- Latency in cycles, with mem_ready high on the first request cycle:
  - Branch: 3.
  - R-type, I-type and SW: 4.
  - LW: 5.
- Each cycle that mem_ready is low in FETCH or MEM adds one cycle; mem_req, iord and mem_we stay stable while waiting.
- reg_write and branch are single-cycle pulses per instruction.

## Configuration
- MCTRL_PERF_EN defined:
  - cycle_count increments every clk out of reset, except in TRAP.
  - instr_count increments on each transition into FETCH from EXEC, MEM or WB (instruction retired).
  - Both counters wrap modulo 2^CNT_W and reset to 0.
- MCTRL_PERF_EN undefined: the counter ports and counter logic are absent.

## Test plan
- mem_ready tied 1, opcode 0000, func 010: state sequence is FETCH, DECODE, EXEC, WB. In WB, reg_write=1 and reg_dst=1. alu_op=000 and func_q=010 from EXEC onward.
- Opcode 1000 with mem_ready low for 2 cycles in MEM: MEM lasts 3 cycles with mem_req=1, iord=1, mem_we=0 throughout. Then WB with mem_to_reg=1 and reg_write=1.
- Opcode 0110: EXEC has branch=1, branch_ne=1, alu_op=101. FETCH is re-entered 3 cycles after the first FETCH, with no reg_write.
- Opcode 1011: illegal=1 from the cycle after DECODE and held for 20 cycles, with mem_req=0. After a rst pulse, illegal=0 and FETCH resumes.
- rst asserted during a held SW MEM cycle: mem_req and mem_we fall without a clock edge. After release, the next instruction fetches.
- MCTRL_PERF_EN build running R, LW and SW back-to-back with mem_ready=1: instr_count=3 and cycle_count=13.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control
// Multi-cycle main control FSM. Each instruction walks through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB), so the datapath can share a
// single memory port and a single ALU. An opcode that decodes as illegal
// parks the machine in TRAP until reset.
//
// Parameters
//   OPW    opcode width (>= 4); any set bit above bit 3 is illegal
//   FUNCW  func field width, latched into func_q
//   CNT_W  performance counter width (only with MCTRL_PERF_EN)
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   opcode, func  instruction fields, sampled in DECODE
//   mem_ready     memory finishes the current request this cycle
//   mem_req       memory request (FETCH, MEM)
//   mem_we        memory write (MEM of SW)
//   iord          0 = instruction address, 1 = data address
//   ir_write      load IR (FETCH & mem_ready)
//   pc_inc        increment PC (FETCH & mem_ready)
//   alu_op        3-bit ALU-op for the ALU control block
//   func_q        func field latched in DECODE
//   alu_src       ALU B operand is the immediate
//   branch        branch evaluate strobe
//   branch_ne     branch sense is not-equal
//   reg_dst       destination register is rd
//   mem_to_reg    write-back data comes from memory
//   reg_write     register file write strobe
//   illegal       sticky illegal-opcode flag
//   instr_count   retired instructions (MCTRL_PERF_EN only)
//   cycle_count   active cycles (MCTRL_PERF_EN only)
//
// Optional feature: define MCTRL_PERF_EN to build the performance counters.
module multicycle_control #(
    parameter int OPW   = 4,
    parameter int FUNCW = 3,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPW-1:0]   opcode,
    input  logic [FUNCW-1:0] func,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_inc,
    output logic [2:0]       alu_op,
    output logic [FUNCW-1:0] func_q,
    output logic             alu_src,
    output logic             branch,
    output logic             branch_ne,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             illegal
`ifdef MCTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } stateT;

    typedef enum logic [2:0] {
        CL_R   = 3'd0,
        CL_I   = 3'd1,
        CL_BR  = 3'd2,
        CL_LW  = 3'd3,
        CL_SW  = 3'd4,
        CL_ILL = 3'd5
    } classT;

    // Elaboration-time sanity checks on the parameters
    if (OPW < 4) begin : gOpwCheck
        $error("multicycle_control: OPW must be at least 4");
    end
    if (CNT_W < 1) begin : gCntCheck
        $error("multicycle_control: CNT_W must be at least 1");
    end

    stateT state;
    classT cls;
    logic  isBne;

    classT      decCls;
    logic [2:0] decAlu;
    logic       decBne;
    logic       upperZero;

    // Opcode decode. Only the low nibble selects the class; any bit above
    // bit 3 forces the illegal class regardless of the nibble.
    always_comb begin
        decCls    = CL_ILL;
        decAlu    = 3'b000;
        decBne    = 1'b0;
        upperZero = ((opcode >> 4) == '0);
        if (upperZero) begin
            case (opcode[3:0])
                4'b0000: begin decCls = CL_R;  decAlu = 3'b000; end
                4'b0001: begin decCls = CL_I;  decAlu = 3'b001; end
                4'b0010: begin decCls = CL_I;  decAlu = 3'b010; end
                4'b0011: begin decCls = CL_I;  decAlu = 3'b011; end
                4'b0100: begin decCls = CL_I;  decAlu = 3'b100; end
                4'b0111: begin decCls = CL_I;  decAlu = 3'b110; end
                4'b0101: begin decCls = CL_BR; decAlu = 3'b101; end
                4'b0110: begin decCls = CL_BR; decAlu = 3'b101; decBne = 1'b1; end
                4'b1000: begin decCls = CL_LW; decAlu = 3'b111; end
                4'b1001: begin decCls = CL_SW; decAlu = 3'b111; end
                default: begin decCls = CL_ILL; decAlu = 3'b000; end
            endcase
        end
    end

    // Sequencer. The instruction class, ALU-op and func are captured once in
    // DECODE and held until the next DECODE, so later states (and the ALU
    // control block) see a stable view even though the IR may be reloaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FETCH;
            cls    <= CL_R;
            isBne  <= 1'b0;
            alu_op <= 3'b000;
            func_q <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    cls    <= decCls;
                    isBne  <= decBne;
                    alu_op <= decAlu;
                    func_q <= func;
                    state  <= (decCls == CL_ILL) ? TRAP : EXEC;
                end
                EXEC: begin
                    case (cls)
                        CL_LW, CL_SW: state <= MEM;
                        CL_BR:        state <= FETCH;
                        default:      state <= WB;
                    endcase
                end
                MEM: begin
                    if (mem_ready) begin
                        state <= (cls == CL_LW) ? WB : FETCH;
                    end
                end
                WB:      state <= FETCH;
                TRAP:    state <= TRAP;
                default: state <= FETCH;
            endcase
        end
    end

    logic inFetch;
    logic inExec;
    logic inMem;
    logic inWb;

    assign inFetch = (state == FETCH);
    assign inExec  = (state == EXEC);
    assign inMem   = (state == MEM);
    assign inWb    = (state == WB);

    // Moore strobes decoded from the registered state. Reset parks the state
    // in FETCH, so the FETCH-driven strobes are masked by rst to keep every
    // output quiet while reset is held and to drop them immediately when
    // reset arrives mid-instruction.
    assign mem_req    = ~rst & (inFetch | inMem);
    assign ir_write   = ~rst & inFetch & mem_ready;
    assign pc_inc     = ~rst & inFetch & mem_ready;
    assign iord       = inMem;
    assign mem_we     = inMem & (cls == CL_SW);
    assign alu_src    = inMem | (inExec & ((cls == CL_I) | (cls == CL_LW) | (cls == CL_SW)));
    assign branch     = inExec & (cls == CL_BR);
    assign branch_ne  = inExec & (cls == CL_BR) & isBne;
    assign reg_write  = inWb;
    assign reg_dst    = inWb & (cls == CL_R);
    assign mem_to_reg = inWb & (cls == CL_LW);
    assign illegal    = (state == TRAP);

`ifdef MCTRL_PERF_EN
    logic retire;

    // An instruction retires on the edge that returns the machine to FETCH.
    assign retire = (inExec & (cls == CL_BR))
                  | (inMem & mem_ready & (cls == CL_SW))
                  | inWb;

    // Performance counters; cycles spent trapped are not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_count <= '0;
            cycle_count <= '0;
        end else begin
            if (state != TRAP) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (retire) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Self-checking bench for multicycle_control. Each instruction is expanded
// by a transaction-level model into the list of per-cycle output vectors it
// must produce (fetch waits, decode, execute, memory waits, write-back),
// while the same plan drives mem_ready. One compare process checks every
// cycle; directed sections add hand-computed literal checks.
// Works in both builds; counter checks appear only with MCTRL_PERF_EN.
module tb_multicycle_control;

    localparam int OPW   = 5;
    localparam int FUNCW = 3;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [OPW-1:0]   opcode;
    logic [FUNCW-1:0] func;
    logic             mem_ready;
    logic             mem_req, mem_we, iord, ir_write, pc_inc;
    logic [2:0]       alu_op;
    logic [FUNCW-1:0] func_q;
    logic             alu_src, branch, branch_ne, reg_dst, mem_to_reg, reg_write, illegal;
`ifdef MCTRL_PERF_EN
    logic [CNT_W-1:0] instr_count, cycle_count;
`endif

    multicycle_control #(.OPW(OPW), .FUNCW(FUNCW), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .func       (func),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_inc     (pc_inc),
        .alu_op     (alu_op),
        .func_q     (func_q),
        .alu_src    (alu_src),
        .branch     (branch),
        .branch_ne  (branch_ne),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .illegal    (illegal)
`ifdef MCTRL_PERF_EN
        ,
        .instr_count(instr_count),
        .cycle_count(cycle_count)
`endif
    );

    always #5 clk = ~clk;

    // Vector layout: 17 mem_req, 16 mem_we, 15 iord, 14 ir_write, 13 pc_inc,
    // 12 alu_src, 11 branch, 10 branch_ne, 9 reg_dst, 8 mem_to_reg,
    // 7 reg_write, 6 illegal, 5:3 alu_op, 2:0 func_q
    localparam logic [17:0] FULL = 18'h3FFFF;
    localparam logic [17:0] NOALU = 18'h3FFC0;

    logic [17:0] expQ[$];
    logic [17:0] maskQ[$];
    logic [17:0] hist[0:8191];
    int pushCount = 0;
    int popCount = 0;
    int total = 0;
    int passed = 0;
    int modelCycles = 0;
    int modelInstr = 0;
    int cyclesLeft = -1;
    logic [2:0] prevAlu = 3'b000;
    logic [2:0] prevFunc = 3'b000;

    function automatic logic [17:0] dutVec();
        return {mem_req, mem_we, iord, ir_write, pc_inc, alu_src, branch, branch_ne,
                reg_dst, mem_to_reg, reg_write, illegal, alu_op, func_q};
    endfunction

    function automatic logic [17:0] mk(input bit mr, input bit we, input bit io, input bit irw,
                                       input bit src, input bit br, input bit bne, input bit rd,
                                       input bit m2r, input bit rw, input bit ill,
                                       input logic [2:0] a, input logic [2:0] f);
        return {mr, we, io, irw, irw, src, br, bne, rd, m2r, rw, ill, a, f};
    endfunction

    // 0 R-type, 1 I-type, 2 branch, 3 LW, 4 SW, 5 illegal
    function automatic int kindOf(input logic [4:0] op);
        if (op[4]) return 5;
        case (op[3:0])
            4'd0:                         return 0;
            4'd1, 4'd2, 4'd3, 4'd4, 4'd7: return 1;
            4'd5, 4'd6:                   return 2;
            4'd8:                         return 3;
            4'd9:                         return 4;
            default:                      return 5;
        endcase
    endfunction

    function automatic logic [2:0] aluOf(input logic [4:0] op);
        case (op[3:0])
            4'd0:       return 3'b000;
            4'd1:       return 3'b001;
            4'd2:       return 3'b010;
            4'd3:       return 3'b011;
            4'd4:       return 3'b100;
            4'd7:       return 3'b110;
            4'd5, 4'd6: return 3'b101;
            default:    return 3'b111;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    // Per-cycle compare against the model's plan, sampled mid-cycle
    initial begin
        logic [17:0] e, m, v;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                m = maskQ.pop_front();
                v = dutVec();
                hist[popCount] = v;
                total++;
                if (((v ^ e) & m) == 18'h0) passed++;
                else $display("[TB] FAIL cycle %0d outputs: got %05h, want %05h (mask %05h)",
                              popCount, v, e, m);
                popCount++;
            end
        end
    end

    // One clock cycle of stimulus; opcode/func are randomised outside DECODE
    task automatic applyStimulus(input bit rdy, input bit dec, input logic [4:0] op,
                                 input logic [2:0] fn, input logic [17:0] e,
                                 input logic [17:0] m, input bit counts);
        if (cyclesLeft == 0) return;
        if (cyclesLeft > 0) cyclesLeft--;
        mem_ready = rdy;
        opcode    = dec ? op : 5'($urandom);
        func      = dec ? fn : 3'($urandom);
        expQ.push_back(e);
        maskQ.push_back(m);
        pushCount++;
        @(posedge clk);
        #1;
        if (counts) modelCycles++;
    endtask

    // Expand one instruction into its expected cycle sequence
    task automatic runInstr(input logic [4:0] op, input logic [2:0] fn, input int fw,
                            input int mw, input int trapCycles);
        int k;
        bit src;
        k = kindOf(op);
        for (int i = 0; i < fw; i++)
            applyStimulus(1'b0, 1'b0, op, fn, mk(1,0,0,0,0,0,0,0,0,0,0, prevAlu, prevFunc), FULL, 1'b1);
        applyStimulus(1'b1, 1'b0, op, fn, mk(1,0,0,1,0,0,0,0,0,0,0, prevAlu, prevFunc), FULL, 1'b1);
        applyStimulus(1'($urandom), 1'b1, op, fn, mk(0,0,0,0,0,0,0,0,0,0,0, prevAlu, prevFunc), FULL, 1'b1);
        if (k == 5) begin
            for (int t = 0; t < trapCycles; t++)
                applyStimulus(1'($urandom), 1'b0, op, fn, mk(0,0,0,0,0,0,0,0,0,0,1, 3'b0, 3'b0), NOALU, 1'b0);
            return;
        end
        prevAlu  = aluOf(op);
        prevFunc = fn;
        src = (k == 1) || (k == 3) || (k == 4);
        applyStimulus(1'($urandom), 1'b0, op, fn,
                      mk(0,0,0,0, src, k == 2, (k == 2) && (op[3:0] == 4'd6), 0,0,0,0, prevAlu, prevFunc),
                      FULL, 1'b1);
        if (k == 3 || k == 4) begin
            for (int i = 0; i < mw; i++)
                applyStimulus(1'b0, 1'b0, op, fn, mk(1, k == 4, 1,0,1,0,0,0,0,0,0, prevAlu, prevFunc), FULL, 1'b1);
            applyStimulus(1'b1, 1'b0, op, fn, mk(1, k == 4, 1,0,1,0,0,0,0,0,0, prevAlu, prevFunc), FULL, 1'b1);
        end
        if (k == 0 || k == 1 || k == 3)
            applyStimulus(1'($urandom), 1'b0, op, fn,
                          mk(0,0,0,0,0,0,0, k == 0, k == 3, 1, 0, prevAlu, prevFunc), FULL, 1'b1);
        modelInstr++;
    endtask

    // Called at posedge+1; asserts rst mid-cycle, releases it one edge later
    task automatic resetPulse();
        rst = 1'b1;
        #1;
        checkOutput("outputs in reset", int'(dutVec()), 0);
`ifdef MCTRL_PERF_EN
        checkOutput("instr_count in reset", int'(instr_count), 0);
        checkOutput("cycle_count in reset", int'(cycle_count), 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        prevAlu = 3'b000;
        prevFunc = 3'b000;
        modelCycles = 0;
        modelInstr = 0;
        cyclesLeft = -1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int s;
        int cnt;
        rst = 1'b1;
        mem_ready = 1'b0;
        opcode = '0;
        func = '0;
        @(posedge clk);
        #1;
        resetPulse();

        // R-type with func 010
        s = pushCount;
        runInstr(5'b00000, 3'b010, 0, 0, 0);
        checkOutput("R wb reg_write", int'(hist[s+3][7]), 1);
        checkOutput("R wb reg_dst", int'(hist[s+3][9]), 1);
        checkOutput("R exec alu_op", int'(hist[s+2][5:3]), 0);
        checkOutput("R exec func_q", int'(hist[s+2][2:0]), 2);

        // LW with two memory wait cycles
        s = pushCount;
        runInstr(5'b01000, 3'($urandom), 0, 2, 0);
        cnt = 0;
        for (int j = 3; j <= 5; j++)
            if (hist[s+j][17] && hist[s+j][15] && !hist[s+j][16]) cnt++;
        checkOutput("LW held MEM cycles", cnt, 3);
        checkOutput("LW wb mem_to_reg&reg_write", int'(hist[s+6][8] & hist[s+6][7]), 1);

        // BNE followed by an R-type to observe the re-entered FETCH
        s = pushCount;
        runInstr(5'b00110, 3'($urandom), 0, 0, 0);
        runInstr(5'b00000, 3'($urandom), 0, 0, 0);
        checkOutput("BNE branch/branch_ne", int'(hist[s+2][11:10]), 3);
        checkOutput("BNE alu_op", int'(hist[s+2][5:3]), 5);
        checkOutput("BNE refetch ir_write", int'(hist[s+3][14]), 1);
        cnt = 0;
        for (int j = 0; j < 3; j++) cnt += int'(hist[s+j][7]);
        checkOutput("BNE reg_write pulses", cnt, 0);

        // Back-to-back R, LW, SW from reset
        resetPulse();
        runInstr(5'b00000, 3'($urandom), 0, 0, 0);
        runInstr(5'b01000, 3'($urandom), 0, 0, 0);
        runInstr(5'b01001, 3'($urandom), 0, 0, 0);
        checkOutput("model cycles R+LW+SW", modelCycles, 13);
`ifdef MCTRL_PERF_EN
        checkOutput("instr_count R+LW+SW", int'(instr_count), 3);
        checkOutput("cycle_count R+LW+SW", int'(cycle_count), 13);
`endif

        // Illegal opcode 1011 traps for 20 cycles
        s = pushCount;
        runInstr(5'b01011, 3'($urandom), 0, 0, 20);
        cnt = 0;
        for (int j = 2; j < 22; j++)
            if (hist[s+j][6] && !hist[s+j][17]) cnt++;
        checkOutput("trap illegal held", cnt, 20);
`ifdef MCTRL_PERF_EN
        checkOutput("cycle_count frozen in trap", int'(cycle_count), modelCycles);
`endif
        resetPulse();
        runInstr(5'b00001, 3'($urandom), 1, 0, 0);

        // Upper opcode bit set is illegal even with a legal low nibble
        runInstr(5'b10000, 3'($urandom), 1, 0, 3);
        resetPulse();

        // Reset during a held SW MEM cycle
        cyclesLeft = 5;
        runInstr(5'b01001, 3'($urandom), 0, 4, 0);
        checkOutput("SW held mem_we before reset", int'(mem_we), 1);
        resetPulse();
        runInstr(5'b00010, 3'($urandom), 0, 0, 0);

        // Randomised legal instruction stream
        resetPulse();
        repeat (150) begin
            runInstr(5'($urandom_range(0, 9)), 3'($urandom),
                     $urandom_range(0, 2), $urandom_range(0, 2), 0);
        end
`ifdef MCTRL_PERF_EN
        checkOutput("instr_count random", int'(instr_count), modelInstr);
        checkOutput("cycle_count random", int'(cycle_count), modelCycles);
`endif

        @(negedge clk);
        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
